// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the round-robin arbiter
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // One-hot grant vector for a 2-bit client index
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotating-priority picker, search starts at ptr
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic               valid,
  output logic [1:0]         idx
);

  logic [1:0] w_cand;

  // Scan offsets from farthest to nearest so the nearest set bit to ptr wins
  always_comb begin
    valid  = 1'b0;
    idx    = ptr;
    w_cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = ptr + 2'(k);
      if (req[w_cand]) begin
        valid = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-client round-robin arbiter with bounded hold and forced preemption
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [1:0]         gnt_id_o,
  output logic               busy_o,
  output logic               preempt_o
);

  localparam int                 HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e          r_state, w_state;
  logic [1:0]          r_ptr, w_ptr;
  logic [HOLD_W-1:0]   r_hold, w_hold;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt;
  logic [1:0]          r_id, w_id;
  logic                r_pre, w_pre;

  logic                w_valid;
  logic [1:0]          w_idx;

  rr_pick4 u_pick (
    .req   (req_i),
    .ptr   (r_ptr),
    .valid (w_valid),
    .idx   (w_idx)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state;
  end

  // Pointer, hold counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_hold <= '0;
      r_gnt  <= '0;
      r_id   <= '0;
      r_pre  <= 1'b0;
    end else begin
      r_ptr  <= w_ptr;
      r_hold <= w_hold;
      r_gnt  <= w_gnt;
      r_id   <= w_id;
      r_pre  <= w_pre;
    end
  end

  // Next-state logic; owner dropping req takes priority over the hold limit,
  // so a release on the limit edge is reported as normal (no preempt pulse)
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_hold  = r_hold;
    w_gnt   = r_gnt;
    w_id    = r_id;
    w_pre   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_gnt   = onehot4(w_idx);
          w_id    = w_idx;
          w_hold  = '0;
          w_state = GRANT;
        end
      end
      GRANT: begin
        if (!req_i[r_id] || (r_hold == HOLD_LAST)) begin
          w_state = GAP;
          w_gnt   = '0;
          w_ptr   = r_id + 2'd1;
          w_pre   = req_i[r_id];
        end else begin
          w_hold = r_hold + HOLD_W'(1);
        end
      end
      GAP: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
        w_gnt   = '0;
      end
    endcase
  end

  assign gnt_o     = r_gnt;
  assign gnt_id_o  = r_id;
  assign busy_o    = |r_gnt;
  assign preempt_o = r_pre;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - directed and randomized self-checking bench for rr_arbiter_4
module tb_rr_arbiter_4;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_i = 4'b0000;
  logic [3:0] gnt_o;
  logic [1:0] gnt_id_o;
  logic       busy_o;
  logic       preempt_o;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  int m_owner;
  int m_ptr;
  int m_held;
  int m_id;
  bit m_gap;
  bit m_pre;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .gnt_id_o  (gnt_id_o),
    .busy_o    (busy_o),
    .preempt_o (preempt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_id    = 0;
    m_gap   = 1'b0;
    m_pre   = 1'b0;
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // m_held counts how many cycles the current owner has already seen its grant
  task automatic model_edge(input logic [3:0] r);
    int w;
    if (m_owner >= 0) begin
      if (!r[m_owner] || m_held == MH) begin
        m_pre   = r[m_owner];
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_gap   = 1'b1;
      end else begin
        m_held++;
        m_pre = 1'b0;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
      m_pre = 1'b0;
    end else begin
      m_pre = 1'b0;
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_id    = w;
        m_held  = 1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] eg;
    eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    chk("gnt_o",     32'(gnt_o),     eg);
    chk("gnt_id_o",  32'(gnt_id_o),  32'(m_id));
    chk("busy_o",    32'(busy_o),    32'(m_owner >= 0));
    chk("preempt_o", 32'(preempt_o), 32'(m_pre));
  endtask

  task automatic step(input logic [3:0] r);
    @(negedge clk);
    req_i = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_outputs();
  endtask

  task automatic apply_reset();
    req_i = 4'b0000;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_gnt",  32'(gnt_o),    32'd0);
    chk("rst_id",   32'(gnt_id_o), 32'd0);
    chk("rst_busy", 32'(busy_o),   32'd0);
    chk("rst_pre",  32'(preempt_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    int pulses;
    int gcycles;

    apply_reset();

    // single requester for three cycles, then dropped
    gcycles = 0;
    pulses  = 0;
    for (int i = 0; i < 3; i++) begin
      step(4'b0001);
      if (gnt_o == 4'b0001) gcycles++;
    end
    for (int i = 0; i < 2; i++) begin
      step(4'b0000);
      chk("single_gap", 32'(gnt_o), 32'd0);
      if (preempt_o) pulses++;
    end
    chk("single_len", 32'(gcycles), 32'd3);
    chk("single_nopre", 32'(pulses), 32'd0);
    step(4'b0011);
    chk("single_ptr1", 32'(gnt_id_o), 32'd1);

    // preemption with both clients held high
    apply_reset();
    pulses = 0;
    for (int i = 1; i <= 11; i++) begin
      step(4'b0011);
      if (preempt_o) pulses++;
      if (i == 4)  chk("pre_c0_last",  32'(gnt_o), 32'b0001);
      if (i == 5)  chk("pre_pulse0",   32'(preempt_o), 32'd1);
      if (i == 6)  chk("pre_gap2",     32'(gnt_o), 32'd0);
      if (i == 7)  chk("pre_c1_first", 32'(gnt_o), 32'b0010);
      if (i == 10) chk("pre_c1_last",  32'(gnt_o), 32'b0010);
      if (i == 11) chk("pre_pulse1",   32'(preempt_o), 32'd1);
    end
    chk("pre_count", 32'(pulses), 32'd2);

    // owner drops request exactly on the limit edge
    apply_reset();
    for (int i = 0; i < 4; i++) step(4'b0001);
    step(4'b0000);
    chk("limit_drop_gnt", 32'(gnt_o), 32'd0);
    chk("limit_drop_pre", 32'(preempt_o), 32'd0);

    // round robin order with every owner dropping after two cycles; last round checks wrap
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      r = (i == 4) ? 4'b1001 : 4'b1111;
      step(r);
      chk("rr_order", 32'(gnt_id_o), 32'(i % 4));
      step(r);
      step(r & ~(4'b0001 << (i % 4)));
      step(r);
    end

    // asynchronous reset in the middle of a grant
    step(4'b1000);
    step(4'b1000);
    #3;
    apply_reset();
    step(4'b0100);
    chk("post_rst_gnt", 32'(gnt_o), 32'b0100);

    // randomized traffic against the reference model
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step(r);
      if ($urandom_range(0, 149) == 0) begin
        #3;
        apply_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
